// File: rtl/arbitro_mux5_pkg.sv
// Shared encodings for the 5-input mux arbiter: select codes and FSM states.
package arbitro_mux5_pkg;

    // Mux select encodings; the mux itself decodes the same values.
    localparam logic [2:0] SEL_ENTRADA0 = 3'b000;
    localparam logic [2:0] SEL_ENTRADA1 = 3'b001;
    localparam logic [2:0] SEL_ENTRADA2 = 3'b010;
    localparam logic [2:0] SEL_ENTRADA3 = 3'b011;
    localparam logic [2:0] SEL_ENTRADA4 = 3'b100;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CONCEDE = 2'b01,
        ESPERA  = 2'b10
    } estado_t;

    // One-hot grant vector for a select index in 0..4.
    function automatic logic [4:0] onehot5(input logic [2:0] idx);
        return 5'b00001 << idx;
    endfunction

endpackage

// File: rtl/arbitro_mux5_prioridade_rr5.sv
// Combinational round-robin picker: first set request bit searching upward
// from (ultimo+1) mod 5, wrapping around.
module prioridade_rr5
    import arbitro_mux5_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ultimo,
    output logic [2:0] indice,
    output logic       algum
);

    logic [2:0] base;
    logic [9:0] dup;
    logic [4:0] rot;
    logic [2:0] off;
    logic [3:0] soma;

    // Starting search position: the index right after the last one served.
    always_comb begin
        case (ultimo)
            SEL_ENTRADA0: base = SEL_ENTRADA1;
            SEL_ENTRADA1: base = SEL_ENTRADA2;
            SEL_ENTRADA2: base = SEL_ENTRADA3;
            SEL_ENTRADA3: base = SEL_ENTRADA4;
            default:      base = SEL_ENTRADA0;
        endcase
    end

    // Rotating the duplicated vector puts req[(base+k) mod 5] at bit k.
    assign dup = {req, req};
    assign rot = 5'(dup >> base);

    // Lowest set bit of the rotated vector is the winner's offset from base.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        off = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (rot[k]) off = 3'(k);
        end
    end

    assign soma   = {1'b0, base} + {1'b0, off};
    assign indice = (soma >= 4'd5) ? 3'(soma - 4'd5) : soma[2:0];
    assign algum  = |req;

endmodule

// File: rtl/arbitro_mux5.sv
// Round-robin arbiter/sequencer for the shared 5-input, 32-bit selection mux.
// Grants one requester, pulses a start strobe, and holds the grant until the
// resource reports completion (fim) or the watchdog expires.
module arbitro_mux5
    import arbitro_mux5_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned LARG_CONT = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic       fim,
    output logic [2:0] controle,
    output logic [4:0] concede,
    output logic       valido,
    output logic       ocupado,
    output logic       estouro
);

    estado_t                estado_q;
    logic [2:0]             controle_q;
    logic [4:0]             concede_q;
    logic                   valido_q;
    logic                   ocupado_q;
    logic                   estouro_q;
    logic [LARG_CONT-1:0]   cont_q;
    logic [2:0]             ultimo_q;

    logic [2:0]             indice;
    logic                   algum;
    logic                   expira;

    prioridade_rr5 u_prioridade (
        .req    (req),
        .ultimo (ultimo_q),
        .indice (indice),
        .algum  (algum)
    );

    // Watchdog limit reached on this ESPERA cycle; TIMEOUT=0 disables it.
    assign expira = (TIMEOUT != 0) && (cont_q == LARG_CONT'(TIMEOUT - 1));

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            controle_q <= SEL_ENTRADA0;
            concede_q  <= 5'b00000;
            valido_q   <= 1'b0;
            ocupado_q  <= 1'b0;
            estouro_q  <= 1'b0;
            cont_q     <= '0;
            ultimo_q   <= SEL_ENTRADA4;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            valido_q  <= 1'b0;
            estouro_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    // controle keeps its last value while idle so the mux output is stable.
                    if (algum) begin
                        controle_q <= indice;
                        concede_q  <= onehot5(indice);
                        valido_q   <= 1'b1;
                        ocupado_q  <= 1'b1;
                        estado_q   <= CONCEDE;
                    end
                end
                CONCEDE: begin
                    cont_q <= '0;
                    if (fim) begin
                        concede_q <= 5'b00000;
                        ocupado_q <= 1'b0;
                        ultimo_q  <= controle_q;
                        estado_q  <= OCIOSO;
                    end else begin
                        estado_q <= ESPERA;
                    end
                end
                ESPERA: begin
                    // fim takes precedence over a simultaneous watchdog expiry.
                    if (fim || expira) begin
                        estouro_q <= !fim;
                        concede_q <= 5'b00000;
                        ocupado_q <= 1'b0;
                        ultimo_q  <= controle_q;
                        estado_q  <= OCIOSO;
                    end else begin
                        cont_q <= cont_q + LARG_CONT'(1);
                    end
                end
                default: begin
                    concede_q <= 5'b00000;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign controle = controle_q;
    assign concede  = concede_q;
    assign valido   = valido_q;
    assign ocupado  = ocupado_q;
    assign estouro  = estouro_q;

endmodule

// File: tb/tb_arbitro_mux5.sv
// Directed bench for arbitro_mux5 with TIMEOUT=16. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_arbitro_mux5;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] req;
    logic       fim;
    logic [2:0] controle;
    logic [4:0] concede;
    logic       valido;
    logic       ocupado;
    logic       estouro;

    int total = 0;
    int bad   = 0;

    arbitro_mux5 #(
        .TIMEOUT   (16),
        .LARG_CONT (5)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .fim      (fim),
        .controle (controle),
        .concede  (concede),
        .valido   (valido),
        .ocupado  (ocupado),
        .estouro  (estouro)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [2:0] ctl, input logic [4:0] conc,
                        input logic val, input logic ocu, input logic est);
        check({tag, ".controle"}, {5'd0, controle}, {5'd0, ctl});
        check({tag, ".concede"},  {3'd0, concede},  {3'd0, conc});
        check({tag, ".valido"},   {7'd0, valido},   {7'd0, val});
        check({tag, ".ocupado"},  {7'd0, ocupado},  {7'd0, ocu});
        check({tag, ".estouro"},  {7'd0, estouro},  {7'd0, est});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int seq [6] = '{0, 1, 2, 3, 4, 0};
        logic [2:0] idx;

        reset = 1'b1;
        req   = 5'b00000;
        fim   = 1'b0;
        step(2);
        outs("reset", 3'd0, 5'b00000, 0, 0, 0);
        reset = 1'b0;

        // Reset mid-ESPERA with requester 2 granted.
        req = 5'b00100;
        step(1);
        outs("g2_concede", 3'd2, 5'b00100, 1, 1, 0);
        step(1);
        outs("g2_espera", 3'd2, 5'b00100, 0, 1, 0);
        step(1);
        reset = 1'b1;
        #1;
        outs("async_reset", 3'd0, 5'b00000, 0, 0, 0);
        step(1);
        reset = 1'b0;
        req   = 5'b00001;
        step(1);
        outs("post_reset_g0", 3'd0, 5'b00001, 1, 1, 0);
        fim = 1'b1;
        req = 5'b00000;
        step(1);
        outs("g0_done", 3'd0, 5'b00000, 0, 0, 0);
        fim = 1'b0;

        // Full rotation with all requesters active; ultimo restored to 4 first.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        req = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            idx = 3'(seq[i]);
            step(1);
            outs($sformatf("rr%0d_concede", i), idx, 5'b00001 << idx, 1, 1, 0);
            step(1);
            outs($sformatf("rr%0d_espera", i), idx, 5'b00001 << idx, 0, 1, 0);
            fim = 1'b1;
            step(1);
            outs($sformatf("rr%0d_idle", i), idx, 5'b00000, 0, 0, 0);
            fim = 1'b0;
        end
        req = 5'b00000;
        step(1);
        outs("rr_quiet", 3'd0, 5'b00000, 0, 0, 0);

        // Watchdog expiry: ultimo=0 so requester 1 wins; req dropped while granted.
        req = 5'b00010;
        step(1);
        outs("wd_concede", 3'd1, 5'b00010, 1, 1, 0);
        req = 5'b00000;
        step(1);
        outs("wd_espera0", 3'd1, 5'b00010, 0, 1, 0);
        step(15);
        outs("wd_espera15", 3'd1, 5'b00010, 0, 1, 0);
        step(1);
        outs("wd_expired", 3'd1, 5'b00000, 0, 0, 1);
        step(1);
        outs("wd_after", 3'd1, 5'b00000, 0, 0, 0);
        // ultimo=1: search starts at 2, so req=00011 wraps to index 0.
        req = 5'b00011;
        step(1);
        outs("wd_ultimo", 3'd0, 5'b00001, 1, 1, 0);
        fim = 1'b1;
        req = 5'b00000;
        step(1);
        fim = 1'b0;

        // fim coincident with watchdog expiry: ultimo=0, requester 2 wins.
        req = 5'b00100;
        step(1);
        outs("co_concede", 3'd2, 5'b00100, 1, 1, 0);
        req = 5'b00000;
        step(16);
        outs("co_espera15", 3'd2, 5'b00100, 0, 1, 0);
        fim = 1'b1;
        step(1);
        outs("co_done", 3'd2, 5'b00000, 0, 0, 0);
        fim = 1'b0;
        step(1);
        outs("co_after", 3'd2, 5'b00000, 0, 0, 0);

        // Wrap: serve 4, then 10001 grants 0, then 4.
        req = 5'b10000;
        step(1);
        outs("wr_g4", 3'd4, 5'b10000, 1, 1, 0);
        fim = 1'b1;
        step(1);
        fim = 1'b0;
        req = 5'b10001;
        step(1);
        outs("wr_g0", 3'd0, 5'b00001, 1, 1, 0);
        fim = 1'b1;
        step(1);
        fim = 1'b0;
        step(1);
        outs("wr_g4b", 3'd4, 5'b10000, 1, 1, 0);
        fim = 1'b1;
        req = 5'b00000;
        step(1);
        fim = 1'b0;

        // fim in CONCEDE; fim already high in OCIOSO is ignored. ultimo=4 -> index 3.
        req = 5'b01000;
        fim = 1'b1;
        step(1);
        outs("fc_concede", 3'd3, 5'b01000, 1, 1, 0);
        req = 5'b00000;
        step(1);
        outs("fc_done", 3'd3, 5'b00000, 0, 0, 0);
        fim = 1'b0;
        step(2);
        outs("fc_idle", 3'd3, 5'b00000, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitro_mux5.md
Name: arbitro_mux5

Overview:
Round-robin arbiter and sequencer for the shared 5-input, 32-bit selection mux (select encoding 000..100).
- Up to five requesters compete for the shared path.
- The block drives the mux select and a one-hot grant, and pulses a start strobe to the downstream resource.
- It holds the grant until the resource signals completion or a watchdog expires.
- It sits in the multicycle datapath control, beside the main control unit.

Parameters:
TIMEOUT, 16, watchdog limit in cycles spent in ESPERA without fim; 0 disables the watchdog.
LARG_CONT, 5, watchdog counter width; must satisfy 2^LARG_CONT > TIMEOUT.

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req  in  5  request per requester; bit i requests mux input i.
fim  in  1  resource done; sampled in CONCEDE and ESPERA.
controle  out  3  mux select, 000..100; never drives 101..111.
concede  out  5  one-hot grant, or all zero.
valido  out  1  one-cycle start pulse to the resource.
ocupado  out  1  high when state is CONCEDE or ESPERA.
estouro  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=OCIOSO, controle=000, concede=00000, valido=0, ocupado=0, estouro=0, counter=0.
  - Pointer ultimo=4, so index 0 has first priority.
- States: OCIOSO, CONCEDE, ESPERA.
- OCIOSO:
  - If req!=0, pick the first set bit searching (ultimo+1) mod 5 upward with wrap.
  - At the next edge: controle=index, concede bit set, valido=1, state goes to CONCEDE.
  - Latency: req sampled at edge N gives the grant visible after edge N.
  - If req=0, stay in OCIOSO. controle holds its last value so the mux output stays stable; concede=0.
- CONCEDE (exactly one cycle):
  - valido falls at the next edge.
  - If fim=1, go to OCIOSO. Otherwise go to ESPERA with counter=0.
- ESPERA:
  - counter increments each cycle.
  - fim=1: go to OCIOSO.
  - counter==TIMEOUT-1 with fim=0: estouro pulses one cycle, then go to OCIOSO.
  - fim and expiry in the same cycle: fim wins, no estouro.
- On every return to OCIOSO:
  - concede clears at that edge.
  - ultimo is set to the served index, whether the transaction completed or timed out.
- Requester dropping req while granted: ignored; the grant holds until fim or timeout.
- New grant earliest one cycle after return to OCIOSO, so one idle cycle between transactions. Best-case throughput is one transaction per 2 cycles (fim in CONCEDE).
- TIMEOUT=0: ESPERA waits indefinitely for fim; estouro is never asserted.
- fim in OCIOSO: ignored.
- Invariants:
  - concede is one-hot or zero.
  - When concede!=0, controle equals the index of the set concede bit.
  - ocupado == (concede!=0).

Decomposition:
- Shared include file holds:
  - select encodings SEL_ENTRADA0..SEL_ENTRADA4 = 3'b000..3'b100, also used by the mux;
  - state encodings OCIOSO/CONCEDE/ESPERA.
- Natural sub-module: prioridade_rr5.
  - Combinational round-robin picker.
  - Inputs: req[4:0], ultimo[2:0].
  - Outputs: indice[2:0], algum.

Test Plan:
- Reset mid-ESPERA (req=00100 granted), assert reset -> outputs zero same cycle; after release req=00001 -> controle=000, concede=00001.
- req=11111 held, fim asserted one cycle into each ESPERA -> grants in order 0,1,2,3,4,0; each valido one cycle, one idle cycle between grants.
- req=00010 granted, req dropped in CONCEDE, fim=0 with TIMEOUT=16 -> grant held; estouro pulses in the 16th ESPERA cycle; concede clears next edge; ultimo=1.
- fim and expiry coincident (fim=1 exactly at counter=15) -> return to OCIOSO, estouro stays 0.
- After serving index 4, req=10001 -> index 0 granted (wrap); then with req still 10001 -> index 4 granted.
- fim=1 in CONCEDE with req=01000 -> CONCEDE to OCIOSO directly; ocupado high exactly one cycle; controle stays 011 while idle.
